// File: rtl/sram_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_mem_arbiter_pkg
// Shared definitions for the SRAM-style core port to unified-memory arbiter.
//
// Contents:
//   ADDR_W / DATA_W / STRB_W : bus widths used by the core and memory ports
//   WORD_W                   : 32-bit word width used by the rdata registers and
//                              the optional fetch buffer
//   arbState_e               : arbiter FSM state encoding
//   sameWord()               : true when two byte addresses fall in one word
// -----------------------------------------------------------------------------
package sram_mem_arbiter_pkg;

   // Existing bus widths shared by the core-side and memory-side ports
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   // Word width of the registered read data and the fetch buffer entry
   localparam int WORD_W = 32;

   // Arbiter states: one request/wait pair per port, plus the single
   // cycle in which the core is released and samples the read data
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      D_REQ  = 3'd1,
      D_WAIT = 3'd2,
      I_REQ  = 3'd3,
      I_WAIT = 3'd4,
      DONE   = 3'd5
   } arbState_e;

   // Two byte addresses that differ only in the byte offset touch the same word
   function automatic logic sameWord(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] b);
      return a[ADDR_W-1:2] == b[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_mem_arbiter_if
// Unified-memory request/response bus between the arbiter and the memory.
//
// Signals:
//   mem_req      request valid (held until accepted)
//   mem_wr       1 = write, 0 = read
//   mem_wstrb    write byte strobes
//   mem_addr     request address
//   mem_wdata    write data
//   mem_addr_ok  request accepted when mem_req & mem_addr_ok
//   mem_data_ok  one response per accepted request, in order
//   mem_rdata    read response data
//
// Modports:
//   master : the arbiter (drives the request, receives the response)
//   slave  : the memory  (receives the request, drives the response)
// -----------------------------------------------------------------------------
interface sram_mem_arbiter_if;
   import sram_mem_arbiter_pkg::*;

   logic              mem_req;
   logic              mem_wr;
   logic [STRB_W-1:0] mem_wstrb;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_addr_ok;
   logic              mem_data_ok;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_wr,
      output mem_wstrb,
      output mem_addr,
      output mem_wdata,
      input  mem_addr_ok,
      input  mem_data_ok,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_wr,
      input  mem_wstrb,
      input  mem_addr,
      input  mem_wdata,
      output mem_addr_ok,
      output mem_data_ok,
      output mem_rdata
   );

endinterface

// File: rtl/sram_mem_arbiter.sv
// -----------------------------------------------------------------------------
// sram_mem_arbiter
// Merges the core's instruction-fetch port and data port onto one unified
// memory bus. When both ports request in the same cycle they are serviced back
// to back, data first (DATA_FIRST=1) or instruction first (DATA_FIRST=0). The
// core is held with stallreq_from_mem until both accesses have completed, then
// released for exactly one cycle (DONE) in which it samples the registered
// read data. Only one memory transaction is ever outstanding.
//
// Parameters:
//   DATA_FIRST        1: data access before fetch, 0: fetch before data access
//
// Ports:
//   clk               single clock, rising edge
//   rst               asynchronous, active-low reset
//   inst_sram_en      fetch request
//   inst_sram_addr    fetch address (stable while stalled)
//   inst_sram_rdata   fetched instruction (registered)
//   data_sram_en      data access request
//   data_sram_wen     byte write enables, 0 = load
//   data_sram_addr    data address (stable while stalled)
//   data_sram_wdata   store data
//   data_sram_rdata   load data (registered, untouched by stores)
//   stallreq_from_mem stall request to the pipeline stall controller
//   mem               unified memory bus (sram_mem_arbiter_if.master)
//
// Build option:
//   SRAM_ARB_IBUF_EN  adds a one-entry fetch buffer (valid, tag, data). A fetch
//                     whose address equals the tag is answered from the buffer
//                     with no memory transaction; any store touching the
//                     tagged word invalidates the entry. Without the macro
//                     every fetch goes to memory.
// -----------------------------------------------------------------------------
module sram_mem_arbiter
   import sram_mem_arbiter_pkg::*;
#(
   parameter int DATA_FIRST = 1
) (
   input  logic               clk,
   input  logic               rst,

   input  logic               inst_sram_en,
   input  logic [ADDR_W-1:0]  inst_sram_addr,
   output logic [WORD_W-1:0]  inst_sram_rdata,

   input  logic               data_sram_en,
   input  logic [STRB_W-1:0]  data_sram_wen,
   input  logic [ADDR_W-1:0]  data_sram_addr,
   input  logic [DATA_W-1:0]  data_sram_wdata,
   output logic [WORD_W-1:0]  data_sram_rdata,

   output logic               stallreq_from_mem,

   sram_mem_arbiter_if.master mem
);

   arbState_e         state_q, state_d;
   logic [WORD_W-1:0] instRdata_q, instRdata_d;
   logic [WORD_W-1:0] dataRdata_q, dataRdata_d;
   logic              instDone_q, instDone_d;
   logic              dataDone_q, dataDone_d;

   logic              dataIsStore;
   logic              instHit;
   logic [WORD_W-1:0] ibufRdata;

   assign dataIsStore = |data_sram_wen;

`ifdef SRAM_ARB_IBUF_EN
   logic              ibufValid_q, ibufValid_d;
   logic [ADDR_W-1:0] ibufTag_q, ibufTag_d;
   logic [WORD_W-1:0] ibufData_q, ibufData_d;
   logic              storeHitsTag;

   // A pending store that writes any byte of the buffered word makes the
   // buffered copy stale.
   assign storeHitsTag = ibufValid_q && data_sram_en && dataIsStore &&
                         sameWord(data_sram_addr, ibufTag_q);

   // When the store is serviced before the fetch, the fetch must see the new
   // memory contents, so a buffer match does not count as a hit in that case.
   assign instHit   = ibufValid_q && (inst_sram_addr == ibufTag_q) &&
                      !((DATA_FIRST != 0) && storeHitsTag);
   assign ibufRdata = ibufData_q;
`else
   assign instHit   = 1'b0;
   assign ibufRdata = '0;
`endif

   // The stall is purely combinational so a cycle with no request adds no
   // stall; it is forced low while reset is asserted.
   assign stallreq_from_mem = rst && (state_q != DONE) &&
                              (inst_sram_en || data_sram_en);

   assign inst_sram_rdata = instRdata_q;
   assign data_sram_rdata = dataRdata_q;

   // State and read-data registers. Reset abandons any in-flight transaction;
   // a late mem_data_ok then lands outside a wait state and is ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         instRdata_q <= '0;
         dataRdata_q <= '0;
         instDone_q  <= 1'b0;
         dataDone_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         instRdata_q <= instRdata_d;
         dataRdata_q <= dataRdata_d;
         instDone_q  <= instDone_d;
         dataDone_q  <= dataDone_d;
      end
   end

`ifdef SRAM_ARB_IBUF_EN
   // Fetch buffer entry
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ibufValid_q <= 1'b0;
         ibufTag_q   <= '0;
         ibufData_q  <= '0;
      end else begin
         ibufValid_q <= ibufValid_d;
         ibufTag_q   <= ibufTag_d;
         ibufData_q  <= ibufData_d;
      end
   end
`endif

   // Next-state and bus outputs. instDone/dataDone remember which ports have
   // been serviced in the current round so a port is never issued twice.
   always_comb begin
      state_d       = state_q;
      instRdata_d   = instRdata_q;
      dataRdata_d   = dataRdata_q;
      instDone_d    = instDone_q;
      dataDone_d    = dataDone_q;

      mem.mem_req   = 1'b0;
      mem.mem_wr    = 1'b0;
      mem.mem_wstrb = '0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;

`ifdef SRAM_ARB_IBUF_EN
      ibufValid_d   = ibufValid_q;
      ibufTag_d     = ibufTag_q;
      ibufData_d    = ibufData_q;
`endif

      unique case (state_q)
         IDLE: begin
            instDone_d = 1'b0;
            dataDone_d = 1'b0;
            // A buffer hit is served here so the data is registered by DONE
            if (inst_sram_en && instHit) begin
               instDone_d  = 1'b1;
               instRdata_d = ibufRdata;
            end
            if (DATA_FIRST != 0) begin
               if (data_sram_en) begin
                  state_d = D_REQ;
               end else if (inst_sram_en) begin
                  state_d = instHit ? DONE : I_REQ;
               end
            end else begin
               if (inst_sram_en && !instHit) begin
                  state_d = I_REQ;
               end else if (data_sram_en) begin
                  state_d = D_REQ;
               end else if (inst_sram_en) begin
                  state_d = DONE;
               end
            end
         end

         D_REQ: begin
            mem.mem_req   = 1'b1;
            mem.mem_wr    = dataIsStore;
            mem.mem_wstrb = data_sram_wen;
            mem.mem_addr  = data_sram_addr;
            mem.mem_wdata = data_sram_wdata;
            if (mem.mem_addr_ok) begin
               state_d = D_WAIT;
`ifdef SRAM_ARB_IBUF_EN
               if (storeHitsTag) begin
                  ibufValid_d = 1'b0;
               end
`endif
            end
         end

         D_WAIT: begin
            if (mem.mem_data_ok) begin
               dataDone_d = 1'b1;
               // Store responses carry no load data
               if (!dataIsStore) begin
                  dataRdata_d = mem.mem_rdata;
               end
               state_d = (inst_sram_en && !instDone_q) ? I_REQ : DONE;
            end
         end

         I_REQ: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = inst_sram_addr;
            if (mem.mem_addr_ok) begin
               state_d = I_WAIT;
            end
         end

         I_WAIT: begin
            if (mem.mem_data_ok) begin
               instDone_d  = 1'b1;
               instRdata_d = mem.mem_rdata;
`ifdef SRAM_ARB_IBUF_EN
               ibufValid_d = 1'b1;
               ibufTag_d   = inst_sram_addr;
               ibufData_d  = mem.mem_rdata;
`endif
               state_d = (data_sram_en && !dataDone_q) ? D_REQ : DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_mem_arbiter
// Self-checking bench for sram_mem_arbiter. A memory responder on the slave
// side of the bus answers with configurable addr_ok / data_ok delays and keeps
// its own word memory. A reference model predicts, per core round, the ordered
// list of memory operations, the register contents seen in DONE and the number
// of stall cycles. Directed rounds cover the boot fetch, dual access, a
// partial store, a slow addr_ok and a reset in the middle of a wait; a random
// loop follows.
// -----------------------------------------------------------------------------
module tb_sram_mem_arbiter;

   localparam int DATA_FIRST = 1;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } memOp_t;

   logic        clk;
   logic        rst;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stallreq_from_mem;

   sram_mem_arbiter_if memBus();

   sram_mem_arbiter #(.DATA_FIRST(DATA_FIRST)) dut (
      .clk               (clk),
      .rst               (rst),
      .inst_sram_en      (inst_sram_en),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_en      (data_sram_en),
      .data_sram_wen     (data_sram_wen),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_rdata   (data_sram_rdata),
      .stallreq_from_mem (stallreq_from_mem),
      .mem               (memBus)
   );

   int          compareCount = 0;
   int          mismatchCount = 0;

   memOp_t      expQ[$];
   logic [31:0] envMem [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];

   int          cfgDa = 0;
   int          cfgDd = 0;
   int          waitCnt = 0;
   int          respCnt = 0;
   bit          respActive = 0;
   logic [31:0] respData = '0;

   logic [31:0] expInst = '0;
   logic [31:0] expData = '0;
`ifdef SRAM_ARB_IBUF_EN
   bit          ibufValid = 0;
   logic [31:0] ibufTag = '0;
   logic [31:0] ibufData = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compareCount++;
      if (got !== exp) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] initWord(input logic [31:0] a);
      return (a * 32'h9E37_79B1) + 32'h1234_5678;
   endfunction

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                              input logic [3:0] strb);
      logic [31:0] r;
      r = oldW;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[b*8 +: 8] = newW[b*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] envRead(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      return envMem.exists(k) ? envMem[k] : initWord(k);
   endfunction

   function automatic void envWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      envMem[k] = mergeBytes(envRead(k), d, s);
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      return refMem.exists(k) ? refMem[k] : initWord(k);
   endfunction

   function automatic void refWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] k;
      k = {a[31:2], 2'b00};
      refMem[k] = mergeBytes(refRead(k), d, s);
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      envMem[{a[31:2], 2'b00}] = d;
      refMem[{a[31:2], 2'b00}] = d;
   endtask

   // Memory responder: drives addr_ok/data_ok on the falling edge so they are
   // stable at the next rising edge, and checks each offered request against
   // the head of the predicted operation queue every cycle it is offered.
   always @(negedge clk) begin
      memBus.mem_addr_ok = 1'b0;
      memBus.mem_data_ok = 1'b0;
      memBus.mem_rdata   = $urandom;
      if (respActive) begin
         if (respCnt == 0) begin
            memBus.mem_data_ok = 1'b1;
            memBus.mem_rdata   = respData;
            respActive         = 0;
         end else begin
            respCnt--;
         end
      end
      if (memBus.mem_req === 1'b1) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedReq", 32'(memBus.mem_req), 32'h0);
         end else begin
            checkOutput("reqAddr", memBus.mem_addr, expQ[0].addr);
            if (waitCnt < cfgDa) begin
               waitCnt++;
            end else begin
               waitCnt            = 0;
               memBus.mem_addr_ok = 1'b1;
               checkOutput("reqWr", 32'(memBus.mem_wr), 32'(expQ[0].wr));
               checkOutput("reqStrb", 32'(memBus.mem_wstrb), 32'(expQ[0].strb));
               if (expQ[0].wr) begin
                  checkOutput("reqWdata", memBus.mem_wdata, expQ[0].wdata);
                  envWrite(memBus.mem_addr, memBus.mem_wdata, memBus.mem_wstrb);
                  respData = $urandom;
               end else begin
                  respData = envRead(memBus.mem_addr);
               end
               respCnt    = cfgDd;
               respActive = 1;
               void'(expQ.pop_front());
            end
         end
      end
   end

   // One core round: predict memory operations, register contents and stall
   // length from the service-order rules, then drive the round and compare.
   task automatic applyStimulus(input bit iEn, input logic [31:0] iAddr,
                                input bit dEn, input logic [3:0] wen,
                                input logic [31:0] dAddr, input logic [31:0] wdata,
                                input int da, input int dd);
      int     nOps;
      int     stallCnt;
      int     expStall;
      bit     doData;
      bit     hit;
      memOp_t op;
      nOps = 0;
      for (int pass = 0; pass < 2; pass++) begin
         doData = ((pass == 0) == (DATA_FIRST != 0));
         if (doData && dEn) begin
            op.addr = dAddr; op.wr = (wen != 4'b0); op.strb = wen; op.wdata = wdata;
            expQ.push_back(op);
            nOps++;
            if (wen != 4'b0) begin
               refWrite(dAddr, wdata, wen);
`ifdef SRAM_ARB_IBUF_EN
               if (ibufValid && (dAddr[31:2] == ibufTag[31:2])) ibufValid = 0;
`endif
            end else begin
               expData = refRead(dAddr);
            end
         end else if (!doData && iEn) begin
            hit = 0;
`ifdef SRAM_ARB_IBUF_EN
            if (ibufValid && (ibufTag == iAddr)) begin
               hit     = 1;
               expInst = ibufData;
            end
`endif
            if (!hit) begin
               op.addr = iAddr; op.wr = 1'b0; op.strb = 4'b0; op.wdata = 32'h0;
               expQ.push_back(op);
               nOps++;
               expInst = refRead(iAddr);
`ifdef SRAM_ARB_IBUF_EN
               ibufValid = 1;
               ibufTag   = iAddr;
               ibufData  = expInst;
`endif
            end
         end
      end
      expStall = 1 + nOps * (2 + da + dd);

      cfgDa = da;
      cfgDd = dd;
      @(negedge clk);
      inst_sram_en    = iEn;
      inst_sram_addr  = iAddr;
      data_sram_en    = dEn;
      data_sram_wen   = wen;
      data_sram_addr  = dAddr;
      data_sram_wdata = wdata;
      #1;
      stallCnt = 0;
      for (int guard = 0; guard < 200 && stallreq_from_mem === 1'b1; guard++) begin
         stallCnt++;
         @(negedge clk);
         #1;
      end
      if (stallreq_from_mem !== 1'b0) begin
         checkOutput("stallTimeout", 32'(stallreq_from_mem), 32'h0);
      end
      checkOutput("stallCycles", stallCnt, expStall);
      checkOutput("instRdata", inst_sram_rdata, expInst);
      checkOutput("dataRdata", data_sram_rdata, expData);
      checkOutput("opsLeft", expQ.size(), 0);
      expQ.delete();
      inst_sram_en = 1'b0;
      data_sram_en = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("idleStall", 32'(stallreq_from_mem), 32'h0);
      checkOutput("idleReq", 32'(memBus.mem_req), 32'h0);
   endtask

   // Reset while the data access waits for its response; the response then
   // arrives after reset is released and must not reach the registers.
   task automatic resetInWait();
      memOp_t op;
      op.addr = 32'h200; op.wr = 1'b0; op.strb = 4'b0; op.wdata = 32'h0;
      expQ.push_back(op);
      cfgDa = 0;
      cfgDd = 3;
      @(negedge clk);
      data_sram_en   = 1'b1;
      data_sram_addr = 32'h200;
      data_sram_wen  = 4'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rstReq", 32'(memBus.mem_req), 32'h0);
      checkOutput("rstStall", 32'(stallreq_from_mem), 32'h0);
      checkOutput("rstInst", inst_sram_rdata, 32'h0);
      checkOutput("rstData", data_sram_rdata, 32'h0);
      data_sram_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checkOutput("lateData", data_sram_rdata, 32'h0);
         checkOutput("lateStall", 32'(stallreq_from_mem), 32'h0);
         checkOutput("lateReq", 32'(memBus.mem_req), 32'h0);
      end
      checkOutput("rstOpsLeft", expQ.size(), 0);
      expQ.delete();
      expInst = '0;
      expData = '0;
`ifdef SRAM_ARB_IBUF_EN
      ibufValid = 0;
`endif
   endtask

   initial begin
      memBus.mem_addr_ok = 1'b0;
      memBus.mem_data_ok = 1'b0;
      memBus.mem_rdata   = '0;
      rst             = 1'b0;
      inst_sram_en    = 1'b0;
      inst_sram_addr  = '0;
      data_sram_en    = 1'b0;
      data_sram_wen   = '0;
      data_sram_addr  = '0;
      data_sram_wdata = '0;

      repeat (2) @(negedge clk);
      #1;
      checkOutput("resetReq", 32'(memBus.mem_req), 32'h0);
      checkOutput("resetInst", inst_sram_rdata, 32'h0);
      checkOutput("resetData", data_sram_rdata, 32'h0);
      data_sram_en = 1'b1;
      #1;
      checkOutput("resetStall", 32'(stallreq_from_mem), 32'h0);
      data_sram_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("postResetStall", 32'(stallreq_from_mem), 32'h0);

      $display("[TB] boot fetch");
      preload(32'hBFC0_0000, 32'h3C08_0001);
      applyStimulus(1, 32'hBFC0_0000, 0, 4'b0, 32'h0, 32'h0, 0, 0);
      checkOutput("bootWord", inst_sram_rdata, 32'h3C08_0001);

      $display("[TB] dual access");
      preload(32'h100, 32'h1111_2222);
      preload(32'h200, 32'h3333_4444);
      applyStimulus(1, 32'h100, 1, 4'b0, 32'h200, 32'h0, 0, 0);
      checkOutput("dualInst", inst_sram_rdata, 32'h1111_2222);
      checkOutput("dualData", data_sram_rdata, 32'h3333_4444);

      $display("[TB] partial store");
      preload(32'h80, 32'hCAFE_0000);
      applyStimulus(0, 32'h0, 1, 4'b0011, 32'h80, 32'hDEAD_BEEF, 0, 0);
      checkOutput("storeKeepsData", data_sram_rdata, 32'h3333_4444);
      applyStimulus(0, 32'h0, 1, 4'b0000, 32'h80, 32'h0, 1, 1);
      checkOutput("storeMerged", data_sram_rdata, 32'hCAFE_BEEF);

      $display("[TB] slow addr_ok");
      applyStimulus(0, 32'h0, 1, 4'b0, 32'h84, 32'h0, 4, 0);

`ifdef SRAM_ARB_IBUF_EN
      $display("[TB] fetch buffer");
      applyStimulus(1, 32'h140, 0, 4'b0, 32'h0, 32'h0, 0, 0);
      applyStimulus(1, 32'h140, 0, 4'b0, 32'h0, 32'h0, 0, 0);
      applyStimulus(0, 32'h0, 1, 4'b0100, 32'h142, 32'h00AB_0000, 0, 0);
      applyStimulus(1, 32'h140, 0, 4'b0, 32'h0, 32'h0, 0, 0);
`endif

      $display("[TB] reset during wait");
      resetInWait();

      $display("[TB] random rounds");
      for (int n = 0; n < 60; n++) begin
         bit          iEn;
         bit          dEn;
         logic [3:0]  wen;
         logic [31:0] iAddr;
         logic [31:0] dAddr;
         int          kind;
         kind  = $urandom_range(0, 2);
         iEn   = (kind != 1);
         dEn   = (kind != 0);
         iAddr = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
         dAddr = 32'h100 + 32'($urandom_range(0, 7)) * 32'd4;
         wen   = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
         applyStimulus(iEn, iAddr, dEn, wen, dAddr, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/sram_mem_arbiter.md
SRAM_MEM_ARBITER -- requirements
Module: sram_mem_arbiter

Interface
REQ-001 The block SHALL take parameter DATA_FIRST, default 1, selecting data-before-instruction service order (1) or instruction-before-data order (0) when both requests are present.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 inst_sram_en  input  1  core instruction fetch request.
REQ-005 inst_sram_addr  input  32  fetch address, held stable while stallreq_from_mem=1.
REQ-006 inst_sram_rdata  output  32  fetched instruction, registered.
REQ-007 data_sram_en  input  1  core data access request.
REQ-008 data_sram_wen  input  4  byte write enables; 0 means load.
REQ-009 data_sram_addr  input  32  data address, held stable while stalled.
REQ-010 data_sram_wdata  input  32  store data.
REQ-011 data_sram_rdata  output  32  load data, registered.
REQ-012 stallreq_from_mem  output  1  pipeline stall request to the stall controller.
REQ-013 mem_req  output  1  unified-memory request valid.
REQ-014 mem_wr  output  1  1=write, 0=read.
REQ-015 mem_wstrb  output  4  write byte strobes.
REQ-016 mem_addr  output  32  request address.
REQ-017 mem_wdata  output  32  write data.
REQ-018 mem_addr_ok  input  1  request accepted when mem_req&mem_addr_ok.
REQ-019 mem_data_ok  input  1  response valid, one per accepted request, in order.
REQ-020 mem_rdata  input  32  read response data.

Function
REQ-021 FSM states SHALL be IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE.
REQ-022 IDLE: if any enable set, go to the first serviced port's REQ state per DATA_FIRST; else stay.
REQ-023 x_REQ: mem_req=1 with that port's address/wr/strb/wdata; on mem_addr_ok go to x_WAIT; mem_req SHALL NOT drop before acceptance.
REQ-024 x_WAIT: mem_req=0; on mem_data_ok capture mem_rdata into that port's rdata register (loads and fetches only), then go to the other port's REQ if that port is enabled and unserviced, else DONE.
REQ-025 Instruction fetches SHALL always be reads (mem_wr=0, mem_wstrb=0); a store SHALL leave data_sram_rdata unchanged.
REQ-026 stallreq_from_mem SHALL be combinationally 1 when state!=DONE and (inst_sram_en|data_sram_en), else 0; zero added stall when both enables are 0.
REQ-027 DONE SHALL last exactly one cycle (core advances, sampling rdata), then go to IDLE; rdata registers SHALL hold until overwritten by the next capture.
REQ-028 At most one memory transaction outstanding; mem_data_ok outside x_WAIT SHALL be ignored.
REQ-029 Minimum latency with addr_ok and data_ok each one cycle after request: single access stalls 3 cycles, dual access 5.

Reset
REQ-030 On rst=0, state=IDLE, mem_req=0, stall=0, both rdata registers=0 immediately; an in-flight transaction is abandoned and its late data_ok ignored.

Configuration
REQ-031 With SRAM_ARB_IBUF_EN defined, a one-entry fetch buffer (valid, tag addr, data) SHALL serve inst_sram_addr==tag with no memory transaction, treated as already serviced, and any store overlapping the tag SHALL clear valid; without it every fetch goes to memory.

Structure
REQ-032 State encodings and the 32-bit width constant SHALL live in the shared defines package next to the existing bus widths; no sub-module is required, the optional fetch buffer is inline.

Verification
REQ-033 Fetch only, addr 0xBFC00000, mem returns 0x3C080001 -> 3 stall cycles, inst_sram_rdata=0x3C080001 in DONE.
REQ-034 Fetch 0x100 plus load 0x200 (DATA_FIRST=1) -> data request issued first, then fetch; 5 stall cycles, both rdata correct.
REQ-035 Store wen=4'b0011 to 0x80 data 0xDEADBEEF -> mem_wr=1, mem_wstrb=0011, data_sram_rdata unchanged.
REQ-036 mem_addr_ok held low 4 cycles -> mem_req and mem_addr stable throughout, stall continuous.
REQ-037 rst asserted in D_WAIT, data_ok arrives after release -> IDLE, outputs 0, response ignored.
REQ-038 SRAM_ARB_IBUF_EN: two fetches of 0x100 -> second stalls 0 memory cycles; store to 0x100 between them -> second fetch reissued.
